sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Sequencer and two-port arbiter for the shared external SRAM bus (21-bit byte address, 8-bit data, active-low write enable). It sits inside `system` between the CPU/chipset memory interface and the video fetch unit, and drives the single SRAM bus that the top level splits across the two 512 KB chips by address bit 19. It owns all SRAM timing: address setup, write-pulse width, read sampling and bus turnaround. It grants the bus round-robin so neither requester starves.

## Interface

Parameters:
- ACCESS_CYCLES, 2, clocks the address is held before read data is sampled (≥1)
- WE_PULSE, 2, clocks `sram_we_n` is held low per write (≥1)

Ports:
- clk_chipset  in  1  system clock (50 MHz); one clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, level, held until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  21  byte address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid while `cpu_ack` = 1
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video read request, level, held until `vid_ack`
- vid_addr  in  21  byte address
- vid_rdata  out  8  read data, valid while `vid_ack` = 1
- vid_ack  out  1  one-cycle completion pulse
- sram_addr  out  21  SRAM address
- sram_dout  out  8  SRAM write data
- sram_oe  out  1  1 = drive `sram_dout` onto the data bus
- sram_din  in  8  SRAM read data
- sram_we_n  out  1  SRAM write enable, active low

## Operation

- All outputs are registered. Reset values: `sram_addr` = 0, `sram_dout` = 0, `sram_oe` = 0, `sram_we_n` = 1, both acks 0, both rdata 0, `last_grant` = CPU.
- FSM states: IDLE, READ, WSETUP, WPULSE, WHOLD, TURN.
- IDLE: if neither request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that is not `last_grant`, then update `last_grant`.
  - On grant, latch addr, we and wdata into `sram_addr` and `sram_dout`. Video is always a read.
  - Next state is READ, or WSETUP for a CPU write.
- READ: stays ACCESS_CYCLES cycles with `sram_oe` = 0 and `sram_we_n` = 1.
  - On the last edge, capture `sram_din` into the granted rdata, set the granted ack, and go to TURN.
- TURN: one cycle, ack high, then go to IDLE.
- WSETUP: one cycle, `sram_oe` = 1, `sram_we_n` = 1.
- WPULSE: WE_PULSE cycles, `sram_oe` = 1, `sram_we_n` = 0.
- WHOLD: one cycle, `sram_we_n` = 1, `sram_oe` = 1, `cpu_ack` = 1; `cpu_rdata` is unchanged. Then go to IDLE.
- Address and data are stable throughout every access. `sram_we_n` never falls in the same cycle the address changes.
- Acks are exactly one cycle and never assert for the non-granted port.
- Requesters must drop `req` at the edge that ends their ack cycle. IDLE re-evaluates requests on the following edge.
- Address is passed unmodified. Bank selection by bit 19 is external, so addresses 0x7FFFF/0x80000 need no special handling.
- Reset asserted mid-access asynchronously forces `sram_we_n` = 1, `sram_oe` = 0, acks = 0 and state = IDLE. The interrupted access is dropped with no ack.

## Timing

- Edge E0 in IDLE samples the request.
- Read (defaults): address valid from E0 to E3; `sram_din` sampled at E2; ack and rdata high during the cycle E2–E3. Request-to-ack is ACCESS_CYCLES edges; occupancy is ACCESS_CYCLES+2 cycles including IDLE (4).
- Write (defaults): WSETUP E0–E1; `sram_we_n` low E1–E3; WHOLD and `cpu_ack` E3–E4. Occupancy is WE_PULSE+3 cycles (5).
- Interleaved video/CPU reads under contention reach one grant every 4 cycles.

## Test plan

- CPU read at addr 0x12345, `sram_din` = 0xA5 → `sram_addr` = 0x12345 from E0; `cpu_ack` high exactly one cycle, 2 edges after sample; `cpu_rdata` = 0xA5; `sram_we_n` stays 1.
- CPU write 0x3C to 0x80001 → `sram_oe` = 1 for 4 cycles; `sram_we_n` low exactly 2 cycles, starting 1 cycle after address valid; `cpu_ack` in the hold cycle.
- `cpu_req` and `vid_req` rise together after reset, both held across 4 accesses → grant order VID, CPU, VID, CPU; each ack once per grant, never overlapping.
- Continuous `vid_req` with sequential addresses, single CPU read injected → CPU served within one video access (≤4 cycles wait); video resumes afterwards.
- Reset asserted during WPULSE → `sram_we_n` = 1 and `sram_oe` = 0 immediately, no `cpu_ack`; after release a fresh request completes normally.
- ACCESS_CYCLES = 3, WE_PULSE = 1 → read ack 3 edges after sample; write low pulse 1 cycle; occupancy 5 and 4 cycles respectively.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin CPU/video arbiter and timing sequencer for the shared external SRAM bus.
// All outputs are registered. Reads ack ACCESS_CYCLES edges after grant; writes ack WE_PULSE+1 edges after grant.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int WE_PULSE      = 2
) (
  input  logic        clk_chipset,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [20:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_oe,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WSETUP = 3'd2;
  localparam logic [2:0] S_WPULSE = 3'd3;
  localparam logic [2:0] S_WHOLD  = 3'd4;
  localparam logic [2:0] S_TURN   = 3'd5;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_VID = 1'b1;

  // Down-counter only ever holds (cycles - 1), so clog2 of the larger count is enough.
  localparam int MAX_CNT = (ACCESS_CYCLES > WE_PULSE) ? ACCESS_CYCLES : WE_PULSE;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] READ_LOAD = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] WE_LOAD   = CW'(WE_PULSE - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_grant;
  logic          r_gnt_vid;
  logic [20:0]   r_addr;
  logic [7:0]    r_dout;
  logic          r_oe;
  logic          r_we_n;
  logic [7:0]    r_cpu_rdata;
  logic          r_cpu_ack;
  logic [7:0]    r_vid_rdata;
  logic          r_vid_ack;

  logic w_any_req;
  logic w_pick_vid;
  logic w_cpu_write;

  assign w_any_req   = cpu_req | vid_req;
  assign w_pick_vid  = vid_req & (~cpu_req | (r_last_grant == GNT_CPU));
  assign w_cpu_write = ~w_pick_vid & cpu_we;

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= GNT_CPU;
      r_gnt_vid    <= 1'b0;
      r_addr       <= '0;
      r_dout       <= '0;
      r_oe         <= 1'b0;
      r_we_n       <= 1'b1;
      r_cpu_rdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_vid_rdata  <= '0;
      r_vid_ack    <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_oe   <= 1'b0;
          r_we_n <= 1'b1;
          if (w_any_req) begin
            r_last_grant <= w_pick_vid ? GNT_VID : GNT_CPU;
            r_gnt_vid    <= w_pick_vid;
            r_addr       <= w_pick_vid ? vid_addr : cpu_addr;
            if (w_cpu_write) begin
              // Data is driven a full cycle before the write pulse to give setup time.
              r_dout  <= cpu_wdata;
              r_oe    <= 1'b1;
              r_state <= S_WSETUP;
            end else begin
              r_cnt   <= READ_LOAD;
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_cnt == '0) begin
            if (r_gnt_vid) begin
              r_vid_rdata <= sram_din;
              r_vid_ack   <= 1'b1;
            end else begin
              r_cpu_rdata <= sram_din;
              r_cpu_ack   <= 1'b1;
            end
            r_state <= S_TURN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_TURN: begin
          r_state <= S_IDLE;
        end
        S_WSETUP: begin
          r_we_n  <= 1'b0;
          r_cnt   <= WE_LOAD;
          r_state <= S_WPULSE;
        end
        S_WPULSE: begin
          if (r_cnt == '0) begin
            r_we_n    <= 1'b1;
            r_cpu_ack <= 1'b1;
            r_state   <= S_WHOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WHOLD: begin
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_oe    <= 1'b0;
          r_we_n  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign sram_oe   = r_oe;
  assign sram_we_n = r_we_n;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign vid_rdata = r_vid_rdata;
  assign vid_ack   = r_vid_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (default timing and ACCESS_CYCLES=3/WE_PULSE=1)
// checked every cycle against a transaction-timeline model with a reference memory.
module tb_sram_arbiter;

  logic        clk_chipset = 1'b0;
  logic        reset_n     = 1'b0;
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [20:0] cpu_addr  [2];
  logic [7:0]  cpu_wdata [2];
  logic [7:0]  cpu_rdata [2];
  logic        cpu_ack   [2];
  logic        vid_req   [2];
  logic [20:0] vid_addr  [2];
  logic [7:0]  vid_rdata [2];
  logic        vid_ack   [2];
  logic [20:0] sram_addr [2];
  logic [7:0]  sram_dout [2];
  logic        sram_oe   [2];
  logic [7:0]  sram_din  [2];
  logic        sram_we_n [2];

  always #5 clk_chipset = ~clk_chipset;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter #(
      .ACCESS_CYCLES(g == 0 ? 2 : 3),
      .WE_PULSE     (g == 0 ? 2 : 1)
    ) u_dut (
      .clk_chipset(clk_chipset),
      .reset_n    (reset_n),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .cpu_ack    (cpu_ack[g]),
      .vid_req    (vid_req[g]),
      .vid_addr   (vid_addr[g]),
      .vid_rdata  (vid_rdata[g]),
      .vid_ack    (vid_ack[g]),
      .sram_addr  (sram_addr[g]),
      .sram_dout  (sram_dout[g]),
      .sram_oe    (sram_oe[g]),
      .sram_din   (sram_din[g]),
      .sram_we_n  (sram_we_n[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  int pct      = 0;

  // Transaction-level model: the most recent grant and when the arbiter next samples.
  bit          m_has [2];
  bit          m_we  [2];
  bit          m_port[2];
  bit          m_last[2];
  int          m_e0  [2];
  int          m_next[2];
  logic [20:0] m_addr[2];
  logic [7:0]  m_wdata[2];
  logic [7:0]  m_exp [2];
  logic [7:0]  m_crd [2];
  logic [7:0]  m_vrd [2];
  bit [7:0]    ref_mem [int];
  bit [7:0]    bus_mem [int];

  bit          cbusy[2], vbusy[2], auto_c[2], auto_v[2], vseq[2];
  logic [20:0] vnext[2];
  int          c_issue[2], c_ack[2], cpu_acks[2], vid_acks[2];
  int          wlow[2], oe_cyc[2], glen[2];
  int          glog[2][16];

  function automatic int ac_of(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int wp_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int key(int d, logic [20:0] a);
    return d * 32'h200000 + int'({11'd0, a});
  endfunction

  function automatic logic [7:0] init_val(logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(bit from_bus, int d, logic [20:0] a);
    int k;
    k = key(d, a);
    if (from_bus) return bus_mem.exists(k) ? bus_mem[k] : init_val(a);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(a);
  endfunction

  function automatic logic [20:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 21'h7FFFF;
      1:       return 21'h80000;
      2:       return 21'h1FFFFF;
      3:       return 21'h00000;
      default: return 21'h7FFF8 + 21'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic chk(string tag, int d, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s dut%0d edge %0d: got 0x%0h expected 0x%0h", tag, d, edge_n, got, exp);
    end
  endtask

  task automatic model_check(int d);
    int c, ac, wp;
    bit e_oe, e_wen, e_cack, e_vack;
    ac = ac_of(d);
    wp = wp_of(d);
    if (!reset_n) begin
      m_has[d]  = 1'b0;
      m_last[d] = 1'b0;
      m_next[d] = edge_n + 1;
      m_crd[d]  = 8'h00;
      m_vrd[d]  = 8'h00;
    end else if (edge_n == m_next[d]) begin
      if (cpu_req[d] || vid_req[d]) begin
        m_port[d]  = vid_req[d] && (!cpu_req[d] || m_last[d] == 1'b0);
        m_last[d]  = m_port[d];
        m_we[d]    = !m_port[d] && cpu_we[d];
        m_addr[d]  = m_port[d] ? vid_addr[d] : cpu_addr[d];
        m_wdata[d] = cpu_wdata[d];
        m_e0[d]    = edge_n;
        m_has[d]   = 1'b1;
        if (m_we[d]) begin
          ref_mem[key(d, m_addr[d])] = m_wdata[d];
          m_next[d] = edge_n + wp + 3;
        end else begin
          m_exp[d]  = mem_rd(1'b0, d, m_addr[d]);
          m_next[d] = edge_n + ac + 2;
        end
      end else begin
        m_next[d] = edge_n + 1;
      end
    end
    c = edge_n - m_e0[d];
    e_oe = 1'b0; e_wen = 1'b1; e_cack = 1'b0; e_vack = 1'b0;
    if (m_has[d]) begin
      if (m_we[d]) begin
        e_oe   = (c <= wp + 1);
        e_wen  = !(c >= 1 && c <= wp);
        e_cack = (c == wp + 1);
      end else if (c == ac) begin
        if (m_port[d]) begin e_vack = 1'b1; m_vrd[d] = m_exp[d]; end
        else begin e_cack = 1'b1; m_crd[d] = m_exp[d]; end
      end
    end
    chk("sram_addr", d, sram_addr[d], m_has[d] ? m_addr[d] : 21'h0);
    chk("sram_oe", d, sram_oe[d], e_oe);
    chk("sram_we_n", d, sram_we_n[d], e_wen);
    chk("cpu_ack", d, cpu_ack[d], e_cack);
    chk("vid_ack", d, vid_ack[d], e_vack);
    chk("cpu_rdata", d, cpu_rdata[d], m_crd[d]);
    chk("vid_rdata", d, vid_rdata[d], m_vrd[d]);
    if (!m_has[d]) chk("sram_dout_rst", d, sram_dout[d], 8'h00);
    else if (m_we[d] && c <= wp + 1) chk("sram_dout", d, sram_dout[d], m_wdata[d]);
  endtask

  task automatic bus(int d);
    if (sram_we_n[d] === 1'b0) begin
      bus_mem[key(d, sram_addr[d])] = sram_dout[d];
      wlow[d]++;
    end
    if (sram_oe[d] === 1'b1) oe_cyc[d]++;
    sram_din[d] = mem_rd(1'b1, d, sram_addr[d]);
  endtask

  task automatic issue_cpu(int d, bit we, logic [20:0] a, logic [7:0] w);
    cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
    cbusy[d] = 1'b1; c_issue[d] = edge_n;
  endtask

  task automatic issue_vid(int d, logic [20:0] a);
    vid_req[d] = 1'b1; vid_addr[d] = a; vbusy[d] = 1'b1;
  endtask

  task automatic reqs(int d);
    if (cpu_ack[d] === 1'b1) begin
      cbusy[d] = 1'b0; cpu_req[d] = 1'b0; cpu_acks[d]++; c_ack[d] = edge_n;
      if (glen[d] < 16) glog[d][glen[d]] = 0;
      glen[d]++;
    end
    if (vid_ack[d] === 1'b1) begin
      vbusy[d] = 1'b0; vid_req[d] = 1'b0; vid_acks[d]++;
      if (glen[d] < 16) glog[d][glen[d]] = 1;
      glen[d]++;
    end
    if (!cbusy[d] && auto_c[d] && $urandom_range(0, 99) < pct)
      issue_cpu(d, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
    if (!vbusy[d] && auto_v[d] && $urandom_range(0, 99) < pct) begin
      if (vseq[d]) begin issue_vid(d, vnext[d]); vnext[d] = vnext[d] + 21'd1; end
      else issue_vid(d, rand_addr());
    end
  endtask

  task automatic tick();
    @(negedge clk_chipset);
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      model_check(d);
      bus(d);
      reqs(d);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    for (int d = 0; d < 2; d++) begin auto_c[d] = 1'b0; auto_v[d] = 1'b0; end
    while ((cbusy[0] || vbusy[0] || cbusy[1] || vbusy[1]) && t < 200) begin
      tick();
      t++;
    end
    chk("drain_timeout", 0, t < 200, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; vid_req[d] = 1'b0; cbusy[d] = 1'b0; vbusy[d] = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic cpu_op(bit we, logic [20:0] a, logic [7:0] w);
    for (int d = 0; d < 2; d++) issue_cpu(d, we, a, w);
    drain();
  endtask

  initial begin
    int t, c0;
    int v0[2];
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      vid_req[d] = 1'b0; vid_addr[d] = '0; sram_din[d] = '0;
    end

    // Reset state, then a CPU read of a preloaded location.
    do_reset();
    tick();
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ref_mem[key(d, 21'h12345)] = 8'hA5;
      bus_mem[key(d, 21'h12345)] = 8'hA5;
      issue_cpu(d, 1'b0, 21'h12345, 8'h00);
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("rd_latency", d, c_ack[d] - c_issue[d], ac_of(d) + 1);
      chk("rd_data", d, cpu_rdata[d], 8'hA5);
    end

    // CPU write, pulse shape, then read back.
    for (int d = 0; d < 2; d++) begin wlow[d] = 0; oe_cyc[d] = 0; end
    cpu_op(1'b1, 21'h80001, 8'h3C);
    for (int d = 0; d < 2; d++) begin
      chk("we_low_cycles", d, wlow[d], wp_of(d));
      chk("oe_cycles", d, oe_cyc[d], wp_of(d) + 2);
      chk("wr_latency", d, c_ack[d] - c_issue[d], wp_of(d) + 2);
      chk("wr_rdata_kept", d, cpu_rdata[d], 8'hA5);
    end
    cpu_op(1'b0, 21'h80001, 8'h00);
    for (int d = 0; d < 2; d++) chk("wr_readback", d, cpu_rdata[d], 8'h3C);

    // Chip boundary addresses pass through untouched.
    cpu_op(1'b1, 21'h7FFFF, 8'h11);
    cpu_op(1'b1, 21'h80000, 8'h22);
    cpu_op(1'b0, 21'h7FFFF, 8'h00);
    for (int d = 0; d < 2; d++) chk("bound_lo", d, cpu_rdata[d], 8'h11);
    cpu_op(1'b0, 21'h80000, 8'h00);
    for (int d = 0; d < 2; d++) chk("bound_hi", d, cpu_rdata[d], 8'h22);

    // Simultaneous requests after reset: video first, then strict alternation.
    do_reset();
    reset_n = 1'b1;
    pct = 100;
    for (int d = 0; d < 2; d++) begin
      glen[d] = 0;
      issue_cpu(d, 1'b0, rand_addr(), 8'h00);
      issue_vid(d, rand_addr());
      auto_c[d] = 1'b1; auto_v[d] = 1'b1;
    end
    t = 0;
    while ((glen[0] < 4 || glen[1] < 4) && t < 100) begin tick(); t++; end
    drain();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) chk("grant_order", d, glog[d][i], (i % 2 == 0) ? 1 : 0);

    // Streaming video with one CPU read injected.
    for (int d = 0; d < 2; d++) begin vseq[d] = 1'b1; vnext[d] = 21'h7FFF0; auto_v[d] = 1'b1; end
    pct = 100;
    repeat (9) tick();
    for (int d = 0; d < 2; d++) issue_cpu(d, 1'b0, 21'h7FFF2, 8'h00);
    t = 0;
    while ((cbusy[0] || cbusy[1]) && t < 40) begin tick(); t++; end
    for (int d = 0; d < 2; d++) begin
      chk("cpu_wait", d, (c_ack[d] - c_issue[d]) <= 2 * ac_of(d) + 2, 1'b1);
      v0[d] = vid_acks[d];
    end
    repeat (20) tick();
    for (int d = 0; d < 2; d++) chk("vid_resume", d, (vid_acks[d] - v0[d]) >= 2, 1'b1);
    drain();
    for (int d = 0; d < 2; d++) vseq[d] = 1'b0;

    // Asynchronous reset in the middle of a write pulse.
    issue_cpu(0, 1'b1, 21'h00055, 8'h77);
    t = 0;
    while (sram_we_n[0] !== 1'b0 && t < 20) begin tick(); t++; end
    chk("wpulse_seen", 0, sram_we_n[0], 1'b0);
    @(posedge clk_chipset);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_we_n", 0, sram_we_n[0], 1'b1);
    chk("rst_oe", 0, sram_oe[0], 1'b0);
    chk("rst_ack", 0, cpu_ack[0], 1'b0);
    cpu_req[0] = 1'b0;
    cbusy[0]   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    c0 = cpu_acks[0];
    issue_cpu(0, 1'b1, 21'h00056, 8'h99);
    drain();
    issue_cpu(0, 1'b0, 21'h00056, 8'h00);
    drain();
    chk("post_rst_data", 0, cpu_rdata[0], 8'h99);
    chk("post_rst_acks", 0, cpu_acks[0] - c0, 2);

    // Random mixed traffic on both ports.
    pct = 30;
    for (int d = 0; d < 2; d++) begin
      auto_c[d] = 1'b1; auto_v[d] = 1'b1; c_ack[d] = 0;
      v0[d] = cpu_acks[d] + vid_acks[d] * 65536;
    end
    repeat (1500) tick();
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("rand_cpu_progress", d, (cpu_acks[d] - v0[d] % 65536) > 20, 1'b1);
      chk("rand_vid_progress", d, (vid_acks[d] - v0[d] / 65536) > 20, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
